// File: rtl/ps2_fifo_sb_ctrl.sv
// PS/2 keyboard controller for the system bus: frame receiver with parity/stop/timeout
// checks, scan-code FIFO, sticky error status, interrupt enable and soft reset.
module ps2_fifo_sb_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        req_i,
    input  logic [31:0] write_data_i,
    input  logic        write_enable_i,
    output logic [31:0] read_data_o,
    output logic        interrupt_request_o,
    input  logic        interrupt_return_i,
    input  logic        kclk_i,
    input  logic        kdata_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [31:0] ADDR_SCAN   = 32'h00;
    localparam logic [31:0] ADDR_UNREAD = 32'h04;
    localparam logic [31:0] ADDR_COUNT  = 32'h08;
    localparam logic [31:0] ADDR_STATUS = 32'h0C;
    localparam logic [31:0] ADDR_IRQEN  = 32'h10;
    localparam logic [31:0] ADDR_RESET  = 32'h24;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    logic rd_req, wr_req, soft_rst;
    assign rd_req   = req_i & ~write_enable_i;
    assign wr_req   = req_i & write_enable_i;
    assign soft_rst = wr_req && (addr_i == ADDR_RESET) && (write_data_i == 32'h1);

    // Synchronisers idle high, matching the PS/2 bus idle level.
    logic [SYNC_STAGES-1:0] kclk_sync, kdata_sync;
    logic                   kclk_prev;
    logic                   kclk_s, kdata_s, kfall;

    assign kclk_s  = kclk_sync[SYNC_STAGES-1];
    assign kdata_s = kdata_sync[SYNC_STAGES-1];
    assign kfall   = kclk_prev & ~kclk_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            kclk_sync  <= '1;
            kdata_sync <= '1;
            kclk_prev  <= 1'b1;
        end else if (soft_rst) begin
            kclk_sync  <= '1;
            kdata_sync <= '1;
            kclk_prev  <= 1'b1;
        end else begin
            kclk_sync  <= {kclk_sync[SYNC_STAGES-2:0], kclk_i};
            kdata_sync <= {kdata_sync[SYNC_STAGES-2:0], kdata_i};
            kclk_prev  <= kclk_s;
        end
    end

    // Receiver
    rx_state_e     rx_state_q, rx_state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          rx_push, rx_perr, rx_ferr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            wd_q       <= '0;
        end else if (soft_rst) begin
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            wd_q       <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            wd_q       <= wd_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        wd_d       = '0;
        rx_push    = 1'b0;
        rx_perr    = 1'b0;
        rx_ferr    = 1'b0;
        if (rx_state_q != RX_IDLE) wd_d = wd_q + 1'b1;
        if (kfall) begin
            wd_d = '0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!kdata_s) begin
                        rx_state_d = RX_DATA;
                        bit_cnt_d  = '0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {kdata_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d      = kdata_s;
                    rx_state_d = RX_STOP;
                end
                RX_STOP: begin
                    rx_state_d = RX_IDLE;
                    rx_perr    = ~^{shift_q, par_q};
                    rx_ferr    = ~kdata_s;
                    rx_push    = kdata_s & (^{shift_q, par_q});
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end else if (rx_state_q != RX_IDLE && wd_q == WW'(TIMEOUT_CYCLES)) begin
            // Stalled mid-frame: drop the partial byte.
            rx_state_d = RX_IDLE;
            rx_ferr    = 1'b1;
        end
    end

    // Scan-code FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, pop, push_ok, ovf_set;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = rd_req && (addr_i == ADDR_SCAN) && !empty;
    assign push_ok = rx_push && (!full || pop);
    assign ovf_set = rx_push && full && !pop;

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (soft_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Status, interrupt enable and interrupt
    logic [2:0] status, st_set, st_clr;
    logic       irq_en, irq_pending;

    assign st_set = {rx_ferr, rx_perr, ovf_set};
    assign st_clr = (wr_req && addr_i == ADDR_STATUS) ? write_data_i[2:0] : 3'b000;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status              <= '0;
            irq_en              <= 1'b1;
            irq_pending         <= 1'b0;
            interrupt_request_o <= 1'b0;
        end else if (soft_rst) begin
            status              <= '0;
            irq_en              <= 1'b1;
            irq_pending         <= 1'b0;
            interrupt_request_o <= 1'b0;
        end else begin
            status <= st_set | (status & ~st_clr);
            if (wr_req && addr_i == ADDR_IRQEN) irq_en <= write_data_i[0];
            if (push_ok)
                irq_pending <= 1'b1;
            else if (interrupt_return_i || (pop && count == CW'(1)))
                irq_pending <= 1'b0;
            interrupt_request_o <= irq_pending & irq_en;
        end
    end

    // Bus read path; soft reset leaves the last read value in place.
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            ADDR_SCAN:   rd_mux = empty ? 32'h0 : {24'b0, mem[rd_ptr]};
            ADDR_UNREAD: rd_mux = {31'b0, ~empty};
            ADDR_COUNT:  rd_mux = {{(32-CW){1'b0}}, count};
            ADDR_STATUS: rd_mux = {29'b0, status};
            ADDR_IRQEN:  rd_mux = {31'b0, irq_en};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       read_data_o <= '0;
        else if (rd_req) read_data_o <= rd_mux;
    end

endmodule

// File: tb/tb_ps2_fifo_sb_ctrl.sv
// Directed plus randomized bench for ps2_fifo_sb_ctrl against a queue-based model of the
// controller's register-level behaviour.
module tb_ps2_fifo_sb_ctrl;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;

    localparam logic [31:0] A_SCAN   = 32'h00;
    localparam logic [31:0] A_UNREAD = 32'h04;
    localparam logic [31:0] A_COUNT  = 32'h08;
    localparam logic [31:0] A_STATUS = 32'h0C;
    localparam logic [31:0] A_IRQEN  = 32'h10;
    localparam logic [31:0] A_RESET  = 32'h24;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        req = 1'b0, we = 1'b0, irq, int_ret = 1'b0;
    logic        kclk = 1'b1, kdata = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    logic [7:0] mq[$];
    logic       m_ovf, m_perr, m_ferr, m_irqen, m_pend;

    ps2_fifo_sb_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .req_i(req), .write_data_i(wdata),
        .write_enable_i(we), .read_data_o(rdata), .interrupt_request_o(irq),
        .interrupt_return_i(int_ret), .kclk_i(kclk), .kdata_i(kdata)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: run did not complete within cycle budget");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_ovf = 0; m_perr = 0; m_ferr = 0; m_irqen = 1; m_pend = 0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); addr = a; req = 1; we = 0;
        @(posedge clk); #1; d = rdata; req = 0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); addr = a; wdata = d; req = 1; we = 1;
        @(negedge clk); req = 0; we = 0;
    endtask

    task automatic pulse_ret();
        @(negedge clk); int_ret = 1;
        @(negedge clk); int_ret = 0;
        m_pend = 0;
    endtask

    // Drives f[0..nb-1] onto the PS/2 lines; optionally pulses interrupt_return_i in the
    // cycle the stop bit is acted on (two synchroniser flops plus edge detect).
    task automatic send_bits(input logic [10:0] f, input int nb, input bit ret_on_stop);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk); kdata = f[i];
            repeat (4) @(negedge clk);
            kclk = 0;
            if (ret_on_stop && i == 10) begin
                @(posedge clk); @(posedge clk); #1 int_ret = 1;
                @(posedge clk); #1 int_ret = 0;
                repeat (6) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            kclk = 1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit ret);
        logic par;
        par = (~^b) ^ bad_par;
        send_bits({stop, par, b, 1'b0}, 11, ret);
        if (ret) m_pend = 0;
        if (stop && !bad_par) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(b);
                m_pend = 1;
            end else begin
                m_ovf = 1;
            end
        end
        if (bad_par) m_perr = 1;
        if (!stop)   m_ferr = 1;
    endtask

    task automatic read_scan(input string tag);
        logic [31:0] d, e;
        e = 32'h0;
        if (mq.size() > 0) begin
            e = {24'b0, mq.pop_front()};
            if (mq.size() == 0) m_pend = 0;
        end
        bus_rd(A_SCAN, d);
        chk(tag, d, e);
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        repeat (2) @(negedge clk);
        chk({tag, ":irq"}, {31'b0, irq}, {31'b0, m_pend & m_irqen});
        bus_rd(A_COUNT, d);  chk({tag, ":count"}, d, mq.size());
        bus_rd(A_UNREAD, d); chk({tag, ":unread"}, d, {31'b0, mq.size() != 0});
        bus_rd(A_STATUS, d); chk({tag, ":status"}, d, {29'b0, m_ferr, m_perr, m_ovf});
    endtask

    initial begin
        logic [31:0] d, held;
        m_reset();

        // Reset state
        #22;
        chk("rst:rdata", rdata, 32'h0);
        chk("rst:irq", {31'b0, irq}, 32'h0);
        @(negedge clk); rst = 0;
        check_regs("reset");
        bus_rd(A_IRQEN, d); chk("reset:irqen", d, 32'h1);

        // Async reset in the middle of a frame
        frame(8'h55, 0, 1, 0);
        check_regs("pre_arst");
        bus_rd(A_IRQEN, d);
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5, 0);
        #2 rst = 1;
        #1;
        chk("arst:rdata", rdata, 32'h0);
        chk("arst:irq", {31'b0, irq}, 32'h0);
        m_reset();
        repeat (2) @(negedge clk); rst = 0;
        check_regs("post_arst");

        // Single good frame 0x1C
        frame(8'h1C, 0, 1, 0);
        check_regs("f1c");
        read_scan("f1c:scan");
        check_regs("f1c_read");

        // Overflow: depth+1 frames
        for (int i = 1; i <= DEPTH + 1; i++) frame(8'(i), 0, 1, 0);
        check_regs("ovf");
        for (int i = 0; i < DEPTH; i++) read_scan("ovf:scan");
        bus_wr(A_STATUS, 32'h1); m_ovf = 0;
        check_regs("ovf_clr");

        // Error frames
        frame(8'h1C, 1, 1, 0);
        check_regs("perr");
        bus_wr(A_STATUS, 32'h7); m_perr = 0;
        frame(8'h1C, 0, 0, 0);
        check_regs("ferr");
        bus_wr(A_STATUS, 32'h7); m_ferr = 0;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4, 0);
        repeat (TIMEOUT + 50) @(negedge clk);
        m_ferr = 1;
        check_regs("timeout");
        bus_wr(A_STATUS, 32'h4); m_ferr = 0;
        frame(8'hA7, 0, 1, 0);
        check_regs("after_timeout");
        read_scan("after_timeout:scan");

        // Interrupt enable and return
        bus_wr(A_IRQEN, 32'h0); m_irqen = 0;
        frame(8'h33, 0, 1, 0);
        check_regs("irq_dis");
        bus_wr(A_IRQEN, 32'h1); m_irqen = 1;
        check_regs("irq_en");
        pulse_ret();
        check_regs("irq_ret");
        frame(8'h44, 0, 1, 1);
        check_regs("irq_ret_push");

        // Soft reset
        bus_wr(A_RESET, 32'h2);
        check_regs("sreset_nop");
        frame(8'h66, 1, 1, 0);
        frame(8'h77, 0, 1, 0);
        bus_wr(A_IRQEN, 32'h0); m_irqen = 0;
        check_regs("pre_sreset");
        bus_rd(A_UNREAD, held);
        bus_wr(A_RESET, 32'h1);
        m_reset();
        chk("sreset:rdata_held", rdata, held);
        check_regs("sreset");
        bus_rd(A_IRQEN, d); chk("sreset:irqen", d, 32'h1);
        read_scan("empty:scan");
        check_regs("empty_read");

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            logic [7:0] b;
            b = 8'($urandom_range(255));
            frame(b, $urandom_range(5) == 0, $urandom_range(7) != 0, 0);
            for (int r = $urandom_range(2); r > 0; r--) read_scan("rnd:scan");
            if ($urandom_range(3) == 0) pulse_ret();
            if ($urandom_range(4) == 0) begin
                m_irqen = 1'($urandom_range(1));
                bus_wr(A_IRQEN, {31'b0, m_irqen});
            end
            if ($urandom_range(3) == 0) begin
                logic [2:0] c;
                c = 3'($urandom_range(7));
                bus_wr(A_STATUS, {29'b0, c});
                m_ovf  = m_ovf  & ~c[0];
                m_perr = m_perr & ~c[1];
                m_ferr = m_ferr & ~c[2];
            end
            check_regs("rnd");
        end
        while (mq.size() > 0) read_scan("drain:scan");
        check_regs("drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
